// File: rtl/ha_result_packer.sv
// Packs half-adder (sum, cout) results into WORD_W-bit words with carry count,
// parity and a sticky illegal-result flag, presented on a one-word valid/ready slot.
module ha_result_packer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sum,
  input  logic              in_cout,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [CNT_W-1:0]  out_len,
  output logic [CNT_W-1:0]  out_carry_cnt,
  output logic              out_ep,
  output logic              out_op,
  output logic              err_illegal
);

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [WORD_W-1:0]   acc_word, acc_word_n;
  logic [CNT_W-1:0]    car, car_n;
  logic                in_ready_n;
  logic                out_valid_n;
  logic [WORD_W-1:0]   out_word_n;
  logic [CNT_W-1:0]    out_len_n;
  logic [CNT_W-1:0]    out_carry_cnt_n;
  logic                out_ep_n;
  logic                out_op_n;
  logic                err_n;

  logic                accept;
  logic                slot_free;
  logic                emit;
  logic                load;
  logic [WORD_W-1:0]   fill_word;
  logic [CNT_W-1:0]    fill_len;
  logic [CNT_W-1:0]    fill_car;
  logic [WORD_W-1:0]   ld_word;
  logic [CNT_W-1:0]    ld_len;
  logic [CNT_W-1:0]    ld_car;

  // State and all registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_FILL;
      cnt           <= '0;
      acc_word      <= '0;
      car           <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_word      <= '0;
      out_len       <= '0;
      out_carry_cnt <= '0;
      out_ep        <= 1'b0;
      out_op        <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      acc_word      <= acc_word_n;
      car           <= car_n;
      in_ready      <= in_ready_n;
      out_valid     <= out_valid_n;
      out_word      <= out_word_n;
      out_len       <= out_len_n;
      out_carry_cnt <= out_carry_cnt_n;
      out_ep        <= out_ep_n;
      out_op        <= out_op_n;
      err_illegal   <= err_n;
    end
  end

  // Next-state, packing and output-slot logic
  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    acc_word_n      = acc_word;
    car_n           = car;
    out_valid_n     = out_valid;
    out_word_n      = out_word;
    out_len_n       = out_len;
    out_carry_cnt_n = out_carry_cnt;
    out_ep_n        = out_ep;
    out_op_n        = out_op;
    err_n           = err_illegal;
    emit            = 1'b0;
    load            = 1'b0;
    ld_word         = acc_word;
    ld_len          = cnt;
    ld_car          = car;

    accept    = in_valid && in_ready && (state == S_FILL);
    slot_free = !out_valid || out_ready;
    // Upper bits of acc_word are always zero, so OR-ing places the bit at index cnt
    fill_word = acc_word | (accept ? (WORD_W'(in_sum) << cnt) : '0);
    fill_len  = cnt + CNT_W'(accept);
    fill_car  = car + CNT_W'(accept && in_cout);

    if (out_valid && out_ready) out_valid_n = 1'b0;
    if (accept && in_sum && in_cout) err_n = 1'b1;

    case (state)
      S_FILL: begin
        emit = (fill_len == CNT_W'(WORD_W)) || (flush && (fill_len != '0));
        if (emit && slot_free) begin
          load    = 1'b1;
          ld_word = fill_word;
          ld_len  = fill_len;
          ld_car  = fill_car;
        end else begin
          acc_word_n = fill_word;
          cnt_n      = fill_len;
          car_n      = fill_car;
          if (emit) state_n = S_FULL;
        end
      end
      S_FULL: begin
        // Completed word waits in the packing registers until the slot frees
        if (slot_free) begin
          load    = 1'b1;
          state_n = S_FILL;
        end
      end
      default: state_n = S_FILL;
    endcase

    if (load) begin
      out_valid_n     = 1'b1;
      out_word_n      = ld_word;
      out_len_n       = ld_len;
      out_carry_cnt_n = ld_car;
      out_ep_n        = ^ld_word;
      out_op_n        = ~^ld_word;
      acc_word_n      = '0;
      cnt_n           = '0;
      car_n           = '0;
    end

    in_ready_n = (state_n == S_FILL);
  end

endmodule

// File: tb/tb_ha_result_packer.sv
// Directed and randomized checks of ha_result_packer against a queue-based
// model of accepted samples and emitted words.
module tb_ha_result_packer;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_sum, in_cout, flush;
  logic              out_valid, out_ready;
  logic [WORD_W-1:0] out_word;
  logic [CNT_W-1:0]  out_len, out_carry_cnt;
  logic              out_ep, out_op, err_illegal;

  int checks = 0;
  int errors = 0;

  // Model state: samples of the word being built, and words owed to the consumer
  bit pend_sum[$];
  bit pend_cout[$];
  int q_word[$];
  int q_len[$];
  int q_car[$];
  bit ill = 1'b0;

  bit                hold_chk = 1'b0;
  logic [WORD_W-1:0] hold_word;
  logic [CNT_W-1:0]  hold_len, hold_car;

  always #5 clock = ~clock;

  ha_result_packer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_len(out_len), .out_carry_cnt(out_carry_cnt),
    .out_ep(out_ep), .out_op(out_op), .err_illegal(err_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_emit();
    int w = 0;
    int c = 0;
    foreach (pend_sum[i]) begin
      w += int'(pend_sum[i]) * (1 << i);
      c += int'(pend_cout[i]);
    end
    q_word.push_back(w);
    q_len.push_back(pend_sum.size());
    q_car.push_back(c);
    pend_sum.delete();
    pend_cout.delete();
  endfunction

  function automatic void model_reset();
    pend_sum.delete();
    pend_cout.delete();
    q_word.delete();
    q_len.delete();
    q_car.delete();
    ill = 1'b0;
    hold_chk = 1'b0;
  endfunction

  // One clock: drive on negedge, check consumed word against model, return 1 after posedge
  task automatic step(input bit v, input bit s, input bit c, input bit f, input bit r);
    int ew;
    @(negedge clock);
    if (hold_chk) begin
      chk("hold_word", 32'(out_word), 32'(hold_word));
      chk("hold_len", 32'(out_len), 32'(hold_len));
      chk("hold_carry", 32'(out_carry_cnt), 32'(hold_car));
    end
    chk("err_illegal", 32'(err_illegal), 32'(ill));
    in_valid = v; in_sum = s; in_cout = c; flush = f; out_ready = r;
    if (out_valid && r) begin
      if (q_word.size() == 0) begin
        chk("spurious_word", 32'(out_valid), 32'd0);
      end else begin
        ew = q_word.pop_front();
        chk("word", 32'(out_word), 32'(ew));
        chk("len", 32'(out_len), 32'(q_len.pop_front()));
        chk("carry_cnt", 32'(out_carry_cnt), 32'(q_car.pop_front()));
        chk("ep", 32'(out_ep), 32'($countones(ew) % 2));
        chk("op", 32'(out_op), 32'(1 - ($countones(ew) % 2)));
      end
    end
    hold_chk  = out_valid && !r;
    hold_word = out_word;
    hold_len  = out_len;
    hold_car  = out_carry_cnt;
    if (v && in_ready) begin
      pend_sum.push_back(s);
      pend_cout.push_back(c);
      if (s && c) ill = 1'b1;
    end
    if (pend_sum.size() == WORD_W || (f && in_ready && pend_sum.size() > 0)) model_emit();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #12;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    bit s17;
    bit [7:0] pat;
    in_valid = 0; in_sum = 0; in_cout = 0; flush = 0; out_ready = 0;
    do_reset();

    // Reset state and in_ready rising one edge after release
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    step(0, 0, 0, 0, 1);
    chk("in_ready_rise", 32'(in_ready), 32'd1);

    // Full word 0x4D, zero latency, one cycle valid
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) step(1, pat[i], 0, 0, 1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_word", 32'(out_word), 32'h4D);
    chk("t1_len", 32'(out_len), 32'd8);
    chk("t1_carry", 32'(out_carry_cnt), 32'd0);
    chk("t1_ep", 32'(out_ep), 32'd0);
    chk("t1_op", 32'(out_op), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("t1_valid_drop", 32'(out_valid), 32'd0);

    // Partial word via flush: (1,1),(0,1),(1,1)
    step(1, 0, 1, 0, 1);
    step(1, 1, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    chk("t2_word", 32'(out_word), 32'h02);
    chk("t2_len", 32'(out_len), 32'd3);
    chk("t2_carry", 32'(out_carry_cnt), 32'd2);
    chk("t2_ep", 32'(out_ep), 32'd1);
    chk("t2_op", 32'(out_op), 32'd0);
    step(0, 0, 0, 0, 1);

    // Backpressure: 17 samples with out_ready low
    for (int i = 0; i < 16; i++) step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) & 1'b0, 0, 0);
    chk("t3_in_ready_low", 32'(in_ready), 32'd0);
    chk("t3_valid", 32'(out_valid), 32'd1);
    s17 = 1'($urandom_range(0, 1));
    step(1, s17, 0, 0, 0);
    chk("t3_still_blocked", 32'(in_ready), 32'd0);
    chk("t3_pending", 32'(pend_sum.size()), 32'd0);
    step(1, s17, 0, 0, 1);
    chk("t3_word2_valid", 32'(out_valid), 32'd1);
    chk("t3_in_ready_back", 32'(in_ready), 32'd1);
    step(1, s17, 0, 0, 1);
    chk("t3_17th_taken", 32'(pend_sum.size()), 32'd1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // Illegal sample sticks across later words
    step(1, 1, 1, 0, 1);
    chk("t4_err_set", 32'(err_illegal), 32'd1);
    for (int i = 0; i < 7; i++) step(1, 1'($urandom_range(0, 1)), 0, 0, 1);
    chk("t4_bit0", 32'(out_word[0]), 32'd1);
    chk("t4_carry", 32'(out_carry_cnt), 32'd1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1);
    chk("t4_err_sticky", 32'(err_illegal), 32'd1);

    // Async reset mid-cycle with a word held and 5 samples pending
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("t5_valid0", 32'(out_valid), 32'd0);
    chk("t5_ready0", 32'(in_ready), 32'd0);
    chk("t5_word0", 32'(out_word), 32'd0);
    chk("t5_len0", 32'(out_len), 32'd0);
    chk("t5_carry0", 32'(out_carry_cnt), 32'd0);
    chk("t5_ep_op0", 32'({out_ep, out_op}), 32'd0);
    chk("t5_err0", 32'(err_illegal), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, 0, 0, 1);
    pat = 8'b1000_0010;
    for (int i = 0; i < 8; i++) step(1, pat[i], 0, 0, 1);
    chk("t5_clean_word", 32'(out_word), 32'h82);
    chk("t5_clean_len", 32'(out_len), 32'd8);
    step(0, 0, 0, 0, 1);

    // Ignored flushes: empty packer, and while FULL
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("t6_empty_flush", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) step(1, 1'($urandom_range(0, 1)), 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("t6_no_extra", 32'(out_valid), 32'd0);
    chk("t6_queue_empty", 32'(q_word.size()), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
    end
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    chk("drain_queue", 32'(q_word.size()), 32'd0);
    chk("drain_pending", 32'(pend_sum.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ha_result_packer.md
Name: ha_result_packer

Overview:
- Downstream consumer of the half-adder stage. Takes one (sum, cout) result per accepted cycle.
- Packs the sum bits into WORD_W-bit words and counts the carries in each word.
- Computes even/odd parity per word, flags impossible half-adder results, and presents each word on a valid/ready output with one-word output buffering.

Parameters:
WORD_W, 8, sum bits per packed word (>=2)
CNT_W, 4, width of length/carry counters; must satisfy 2**CNT_W > WORD_W

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream sample valid
in_ready  output  1  block can accept a sample this cycle
in_sum  input  1  half-adder sum bit
in_cout  input  1  half-adder carry bit
flush  input  1  single-cycle request to emit a partial word
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts word
out_word  output  WORD_W  packed sum bits; bit i = i-th accepted sample of the word
out_len  output  CNT_W  number of samples in word (1..WORD_W)
out_carry_cnt  output  CNT_W  number of samples in word with cout=1
out_ep  output  1  XOR-reduction of out_word
out_op  output  1  ~out_ep
err_illegal  output  1  sticky: a sample with sum=1 and cout=1 was accepted

Behaviour:
- Reset (reset=0, async): every output and internal counter goes to 0 immediately, including in_ready, out_valid and err_illegal. The state goes to FILL and the partial word is discarded. in_ready rises on the first clock edge after reset is released.
- Accept: a sample is accepted on a posedge with in_valid && in_ready. The packer holds cnt (0..WORD_W-1) samples, a sum shift register and a carry counter.
- Output slot free: the slot is free when !out_valid || out_ready.
- Word completion: the word completes on the edge where the WORD_W-th sample is accepted.
  - If the slot is free, the output registers load at that same edge: out_valid=1, len=WORD_W, cnt returns to 0.
  - Latency is therefore 0 cycles from the last accept edge.
  - If the slot is not free, the state goes to FULL and holds the completed word.
- FULL state: in_ready=0. On the first edge where the slot is free, the held word loads into the output registers and the state returns to FILL. in_ready=1 again from that edge.
- Flush in FILL: applies when flush=1 and (cnt>0 or a sample is accepted that same cycle). The sample accepted that cycle is included.
  - The partial word is emitted: unfilled high bits are 0, and out_len = samples held.
  - Slot rules are the same as for a full word, so the state goes to FULL if the slot is busy.
  - A flush that completes exactly WORD_W samples behaves as a normal completion.
- Flush ignored: flush is ignored with no sample present, and ignored entirely in FULL.
- Output hold: while out_valid && !out_ready, all out_* signals are stable.
  - When out_ready && out_valid with no new word, out_valid drops the next edge.
  - Back-to-back words are allowed: a new word may load on the same edge as the handshake.
- Parity:
  - out_ep = ^out_word, so {out_word, out_ep} has even parity. out_op = ~out_ep.
  - Both are registered with the word and are valid only while out_valid=1.
- Illegal sample: a sample with in_sum=1 and in_cout=1 is still accepted and packed. err_illegal sets on that edge and clears only on reset.
- in_ready in FILL: in_ready=1, independent of in_valid; there is no combinational path from in_valid to in_ready.
- Counters: never wrap. cnt saturates logically at completion. out_carry_cnt <= out_len always.

Test Plan:
- WORD_W=8, out_ready=1, sums 1,0,1,1,0,0,1,0 with cout=0 -> out_word=0x4D, out_len=8, out_carry_cnt=0, out_ep=0, out_op=1. out_valid is high right after the 8th accept edge, for exactly 1 cycle.
- Inputs (a,b)=(1,1),(0,1),(1,1), i.e. sum=0,1,0 and cout=1,0,1, then flush -> out_word=0x02, out_len=3, out_carry_cnt=2, out_ep=1, out_op=0.
- out_ready=0, drive 17 valid samples. Expected:
  - Word 1 is held.
  - in_ready drops after the 16th accept, and the 17th sample waits.
  - Raise out_ready: word 1 and word 2 appear on consecutive cycles, then the 17th sample is accepted.
- Accept a sample with sum=1 and cout=1 -> err_illegal=1 and stays 1 through later words. Bit is set in out_word and out_carry_cnt counts it. Cleared only by reset.
- Assert reset asynchronously mid-clock after 5 samples, with out_valid=1 -> all outputs 0 immediately. After release, 8 new samples produce a clean word with out_len=8, containing no stale bits.
- flush with cnt=0 and no accept, and flush in FULL -> no output change and no extra word.
